// File: rtl/rx_frame_counter.sv
// rx_frame_counter: oversampling edge/bit counter for the UART receive path.
// Ports: clk, rst (async active-low), enable, prescale, par_en in;
//        edge_cnt, bit_cnt, samp_en, samp_last, bit_done, frame_done, cfg_err out.
module rx_frame_counter #(
    parameter int MAX_PRESCALE = 32,
    parameter int EDGE_W       = $clog2(MAX_PRESCALE),
    parameter int DATA_W       = 8,
    parameter int BIT_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [EDGE_W:0]   prescale,
    input  logic              par_en,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              samp_en,
    output logic              samp_last,
    output logic              bit_done,
    output logic              frame_done,
    output logic              cfg_err
);

    localparam int PW = EDGE_W + 1;
    localparam logic [EDGE_W:0]   PS_MIN = PW'(4);
    localparam logic [EDGE_W:0]   PS_MAX = PW'(MAX_PRESCALE);
    localparam logic [EDGE_W:0]   PS_DEF = PW'(8);
    localparam logic [EDGE_W:0]   P_ONE  = PW'(1);
    localparam logic [EDGE_W:0]   P_TWO  = PW'(2);
    localparam logic [EDGE_W-1:0] E_ONE  = EDGE_W'(1);
    localparam logic [BIT_W-1:0]  B_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0]  B_BASE = BIT_W'(DATA_W + 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [EDGE_W:0]   ps_l;
    logic              par_l;
    logic [EDGE_W-1:0] edge_nxt;
    logic [BIT_W-1:0]  bit_nxt;
    logic              latch;

    logic              ps_legal;
    logic [EDGE_W:0]   ps_new;
    logic [EDGE_W:0]   ps_eff;
    logic              par_eff;
    logic [EDGE_W:0]   edge_x;
    logic [EDGE_W:0]   half;
    logic [BIT_W-1:0]  last_bit;
    logic              wrap_e;
    logic              wrap_f;
    logic              act;

    // While idle the incoming config is the one that will be latched on
    // this cycle, so the first enabled cycle already decodes with it.
    always_comb begin
        ps_legal = (prescale >= PS_MIN) && (prescale <= PS_MAX) &&
                   ((prescale & (prescale - P_ONE)) == '0);
        ps_new   = ps_legal ? prescale : PS_DEF;
        ps_eff   = (state == IDLE) ? ps_new : ps_l;
        par_eff  = (state == IDLE) ? par_en : par_l;
        edge_x   = {1'b0, edge_cnt};
        half     = ps_eff >> 1;
        last_bit = B_BASE + {{(BIT_W-1){1'b0}}, par_eff};
        wrap_e   = (edge_x == ps_eff - P_ONE);
        wrap_f   = wrap_e && (bit_cnt == last_bit);
        act      = enable && rst;
    end

    // Sample window is mid-1..mid+1 with mid = ps/2-1.
    always_comb begin
        samp_en    = act && ((edge_x == half - P_TWO) ||
                             (edge_x == half - P_ONE) ||
                             (edge_x == half));
        samp_last  = act && (edge_x == half);
        bit_done   = act && wrap_e;
        frame_done = act && wrap_f;
    end

    always_comb begin
        state_nxt = state;
        edge_nxt  = edge_cnt;
        bit_nxt   = bit_cnt;
        latch     = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            edge_nxt  = '0;
            bit_nxt   = '0;
        end else begin
            state_nxt = COUNT;
            if (state == IDLE)
                latch = 1'b1;
            if (wrap_e) begin
                edge_nxt = '0;
                if (wrap_f) begin
                    bit_nxt = '0;
                    latch   = 1'b1;
                end else begin
                    bit_nxt = bit_cnt + B_ONE;
                end
            end else begin
                edge_nxt = edge_cnt + E_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            ps_l     <= PS_DEF;
            par_l    <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            edge_cnt <= edge_nxt;
            bit_cnt  <= bit_nxt;
            if (latch) begin
                ps_l    <= ps_new;
                par_l   <= par_en;
                cfg_err <= !ps_legal;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_counter.sv
// tb_rx_frame_counter: directed bench for rx_frame_counter.
// Drives frames at several prescale/parity settings and checks strobes.
module tb_rx_frame_counter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [5:0] prescale;
    logic       par_en;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       samp_en;
    logic       samp_last;
    logic       bit_done;
    logic       frame_done;
    logic       cfg_err;

    int checks = 0;
    int failures = 0;
    int bad, bs, fd1, fd2, nbd, maxb;

    rx_frame_counter dut (
        .clk(clk), .rst(rst), .enable(enable),
        .prescale(prescale), .par_en(par_en),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .samp_en(samp_en), .samp_last(samp_last),
        .bit_done(bit_done), .frame_done(frame_done),
        .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic int strobes();
        return int'(samp_en) + int'(samp_last) + int'(bit_done) + int'(frame_done);
    endfunction

    // Runs n cycles starting at posedge+1; c counts enabled cycles from c0+1.
    task automatic run(input int c0, input int n, input int ps, input int lb,
                       output int o_bad, output int o_bs, output int o_fd1,
                       output int o_fd2, output int o_nbd, output int o_maxb);
        int e, b, mid;
        o_bad = 0; o_bs = 0; o_fd1 = -1; o_fd2 = -1; o_nbd = 0; o_maxb = 0;
        mid = ps / 2 - 1;
        for (int c = c0 + 1; c <= c0 + n; c++) begin
            e = (c - 1) % ps;
            b = ((c - 1) / ps) % (lb + 1);
            #2;
            if (int'(edge_cnt) != e || int'(bit_cnt) != b) o_bad++;
            if (samp_en !== (e >= mid - 1 && e <= mid + 1)) o_bs++;
            if (samp_last !== (e == mid + 1)) o_bs++;
            if (bit_done !== (e == ps - 1)) o_bs++;
            if (frame_done !== (e == ps - 1 && b == lb)) o_bs++;
            if (frame_done === 1'b1) begin
                if (o_fd1 < 0) o_fd1 = c;
                else if (o_fd2 < 0) o_fd2 = c;
            end
            if (bit_done === 1'b1) o_nbd++;
            if (int'(bit_cnt) > o_maxb) o_maxb = int'(bit_cnt);
            adv();
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; prescale = 6'd8; par_en = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_edge", int'(edge_cnt), 0);
        chk("rst_bit", int'(bit_cnt), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_strobes", strobes(), 0);
        adv();
        rst = 1'b1;
        adv();
        adv();

        // 8N1, x8
        enable = 1'b1;
        run(0, 160, 8, 9, bad, bs, fd1, fd2, nbd, maxb);
        chk("t1_counters", bad, 0);
        chk("t1_strobes", bs, 0);
        chk("t1_fd_first", fd1, 80);
        chk("t1_fd_second", fd2, 160);
        chk("t1_bit_done_cnt", nbd, 20);

        // 8E1, x16
        enable = 1'b0; prescale = 6'd16; par_en = 1'b1;
        #2;
        chk("t2_off_strobes", strobes(), 0);
        adv();
        enable = 1'b1;
        run(0, 176, 16, 10, bad, bs, fd1, fd2, nbd, maxb);
        chk("t2_counters", bad, 0);
        chk("t2_strobes", bs, 0);
        chk("t2_fd", fd1, 176);
        chk("t2_bit_done_cnt", nbd, 11);
        chk("t2_max_bit", maxb, 10);

        // x4, then illegal x6
        enable = 1'b0; prescale = 6'd4; par_en = 1'b0;
        adv();
        enable = 1'b1;
        run(0, 40, 4, 9, bad, bs, fd1, fd2, nbd, maxb);
        chk("t3_x4_counters", bad, 0);
        chk("t3_x4_strobes", bs, 0);
        chk("t3_x4_fd", fd1, 40);
        chk("t3_x4_cfg_err", int'(cfg_err), 0);
        prescale = 6'd6;
        run(0, 40, 4, 9, bad, bs, fd1, fd2, nbd, maxb);
        chk("t3_hold_fd", fd1, 40);
        chk("t3_x6_cfg_err", int'(cfg_err), 1);
        run(0, 80, 8, 9, bad, bs, fd1, fd2, nbd, maxb);
        chk("t3_x6_counters", bad, 0);
        chk("t3_x6_fd", fd1, 80);

        // prescale change at bit 3 takes effect next frame
        prescale = 6'd8;
        run(0, 24, 8, 9, bad, bs, fd1, fd2, nbd, maxb);
        chk("t4_pre_counters", bad, 0);
        prescale = 6'd16;
        run(24, 56, 8, 9, bad, bs, fd1, fd2, nbd, maxb);
        chk("t4_cur_counters", bad, 0);
        chk("t4_cur_fd", fd1, 80);
        chk("t4_cfg_err", int'(cfg_err), 0);
        run(0, 160, 16, 9, bad, bs, fd1, fd2, nbd, maxb);
        chk("t4_next_counters", bad, 0);
        chk("t4_next_fd", fd1, 160);

        // drop enable at bit 3 edge 5
        run(0, 53, 16, 9, bad, bs, fd1, fd2, nbd, maxb);
        enable = 1'b0;
        #2;
        chk("t5_drop_edge", int'(edge_cnt), 5);
        chk("t5_drop_bit", int'(bit_cnt), 3);
        adv();
        #2;
        chk("t5_idle_edge", int'(edge_cnt), 0);
        chk("t5_idle_bit", int'(bit_cnt), 0);
        chk("t5_idle_strobes", strobes(), 0);
        adv();
        prescale = 6'd4;
        enable = 1'b1;
        run(0, 39, 4, 9, bad, bs, fd1, fd2, nbd, maxb);
        chk("t5_relatch_counters", bad, 0);
        chk("t5_relatch_strobes", bs, 0);
        enable = 1'b0;
        #2;
        chk("t5_gated_fd", int'(frame_done), 0);
        chk("t5_gated_bd", int'(bit_done), 0);
        adv();
        #2;
        chk("t5_gated_clear", int'(edge_cnt) + int'(bit_cnt), 0);
        adv();

        // async reset at bit 7 edge 2
        prescale = 6'd8;
        enable = 1'b1;
        run(0, 58, 8, 9, bad, bs, fd1, fd2, nbd, maxb);
        #2;
        chk("t6_pre_edge", int'(edge_cnt), 2);
        chk("t6_pre_bit", int'(bit_cnt), 7);
        chk("t6_pre_samp", int'(samp_en), 1);
        rst = 1'b0;
        #1;
        chk("t6_async_edge", int'(edge_cnt), 0);
        chk("t6_async_bit", int'(bit_cnt), 0);
        chk("t6_async_strobes", strobes(), 0);
        adv();
        rst = 1'b1;
        run(0, 80, 8, 9, bad, bs, fd1, fd2, nbd, maxb);
        chk("t6_restart_counters", bad, 0);
        chk("t6_restart_strobes", bs, 0);
        chk("t6_restart_fd", fd1, 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
